seq_echo_responder: RTL and testbench

Responder side of the capture-then-check sequence pattern used in the assertion regression benches. It accepts a `valid_i`/`data_i` stream, holds each accepted byte as an in-flight local capture, and re-drives it on `resp_valid_o`/`resp_data_o` exactly `delay` cycles later. A bench-side `(valid, captured = data) ##N (resp_data == captured)` property can therefore be proven against real hardware. It sits between the stimulus counter and the assertion checkers in the test top.

---
 rtl/seq_echo_pkg.sv | 20 ++
 rtl/seq_echo_pipe.sv | 40 ++++
 rtl/seq_echo_responder.sv | 104 ++++++++++
 tb/tb_seq_echo_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_echo_pkg.sv
// rtl/seq_echo_pkg.sv - shared types, widths and delay clamp for the echo responder
package seq_echo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    ARMED  = 2'd2,
    DRAIN  = 2'd3
  } seq_echo_state_e;

  localparam int SEQ_ECHO_CYC_W = 16;

  // Requested delay 0 means "next cycle"; anything past the pipeline depth saturates.
  function automatic int clamp_delay(input int req, input int max_delay);
    if (req < 1) return 1;
    if (req > max_delay) return max_delay;
    return req;
  endfunction

endpackage

// File: rtl/seq_echo_pipe.sv
// rtl/seq_echo_pipe.sv - valid+data shift pipeline with a selectable output tap
module seq_echo_pipe #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 4,
  parameter int TAP_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAP_W-1:0] tap,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_data,
  output logic             any_valid
);

  logic [MAX_DELAY-1:0] vld;
  logic [WIDTH-1:0]     dat [MAX_DELAY];

  // Stages past the tap never receive a valid bit, so the pipe empties as soon
  // as the last beat has been handed to the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < MAX_DELAY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int i = 1; i < MAX_DELAY; i++) begin
        vld[i] <= vld[i-1] & (i <= int'(tap));
        dat[i] <= dat[i-1];
      end
    end
  end

  assign tap_valid = vld[tap];
  assign tap_data  = dat[tap];
  assign any_valid = |vld;

endmodule

// File: rtl/seq_echo_responder.sv
// rtl/seq_echo_responder.sv - delayed echo of accepted beats; hit counter under SEQ_ECHO_HIT_CNT_EN
module seq_echo_responder
  import seq_echo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MAX_DELAY   = 4,
  parameter int DISABLE_CYC = 2,
  parameter int DLY_W       = $clog2(MAX_DELAY + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [DLY_W-1:0]          delay_i,
  input  logic                      valid_i,
  input  logic [WIDTH-1:0]          data_i,
  output logic                      resp_valid_o,
  output logic [WIDTH-1:0]          resp_data_o,
  output logic                      busy_o,
  output logic [SEQ_ECHO_CYC_W-1:0] cyc_o,
  output logic [15:0]               hit_cnt_o
);

  localparam int TAP_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [SEQ_ECHO_CYC_W-1:0] WARM_LAST =
    SEQ_ECHO_CYC_W'((DISABLE_CYC > 0) ? DISABLE_CYC - 1 : 0);

  seq_echo_state_e           state, state_nxt;
  logic [DLY_W-1:0]          delay_q;
  logic [DLY_W-1:0]          delay_nxt;
  logic [SEQ_ECHO_CYC_W-1:0] cyc;
  logic [TAP_W-1:0]          tap;
  logic                      capture;
  logic                      tap_valid;
  logic [WIDTH-1:0]          tap_data;
  logic                      any_valid;

  // Acceptance looks at the current state, so the beat alongside the en_i drop still lands.
  assign capture   = (state == ARMED) & valid_i;
  assign delay_nxt = DLY_W'(clamp_delay(int'(delay_i), MAX_DELAY));
  assign tap       = TAP_W'(delay_q - DLY_W'(1));

  seq_echo_pipe #(
    .WIDTH     (WIDTH),
    .MAX_DELAY (MAX_DELAY),
    .TAP_W     (TAP_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (capture),
    .in_data   (data_i),
    .tap       (tap),
    .tap_valid (tap_valid),
    .tap_data  (tap_data),
    .any_valid (any_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_i) state_nxt = (DISABLE_CYC == 0) ? ARMED : WARMUP;
      WARMUP: begin
        if (!en_i) state_nxt = IDLE;
        else if (cyc == WARM_LAST) state_nxt = ARMED;
      end
      ARMED:   if (!en_i) state_nxt = DRAIN;
      DRAIN:   if (!any_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      delay_q      <= DLY_W'(1);
      cyc          <= '0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && en_i) delay_q <= delay_nxt;
      if (state == IDLE || state_nxt == IDLE) cyc <= '0;
      else if (cyc != '1) cyc <= cyc + 1'b1;
      resp_valid_o <= tap_valid;
      resp_data_o  <= tap_valid ? tap_data : '0;
    end
  end

  assign busy_o = (state != IDLE) | any_valid;
  assign cyc_o  = cyc;

`ifdef SEQ_ECHO_HIT_CNT_EN
  logic [15:0] hit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt <= '0;
    else if (resp_valid_o && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
  end

  assign hit_cnt_o = hit_cnt;
`else
  assign hit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_echo_responder.sv
// tb/tb_seq_echo_responder.sv - self-checking bench for seq_echo_responder
module tb_seq_echo_responder;

  localparam int WIDTH       = 8;
  localparam int MAX_DELAY   = 4;
  localparam int DISABLE_CYC = 2;
  localparam int DLY_W       = 3;
`ifdef SEQ_ECHO_HIT_CNT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [DLY_W-1:0] dly;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             busy;
  logic [15:0]      cyc;
  logic [15:0]      hit;

  seq_echo_responder #(
    .WIDTH       (WIDTH),
    .MAX_DELAY   (MAX_DELAY),
    .DISABLE_CYC (DISABLE_CYC),
    .DLY_W       (DLY_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .delay_i      (dly),
    .valid_i      (valid),
    .data_i       (data),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .busy_o       (busy),
    .cyc_o        (cyc),
    .hit_cnt_o    (hit)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a mode variable plus a queue of scheduled echoes (edge number, data).
  localparam int M_IDLE = 0, M_WARM = 1, M_ARMED = 2, M_DRAIN = 3;
  typedef struct { int due; int d; } ev_t;
  ev_t m_q[$];
  int  m_mode, m_cyc, m_dly, m_hit, m_edge, m_rv, m_rd;

  typedef struct { int en; int dly; int v; int d; int rv; int rd; int busy; int cyc; } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE; m_cyc = 0; m_dly = 1; m_hit = 0; m_edge = 0; m_rv = 0; m_rd = 0;
  endtask

  task automatic model_edge();
    bit pre_empty;
    int req;
    m_edge++;
    if (m_rv != 0 && m_hit < 65535) m_hit++;
    if (m_mode == M_ARMED && valid) m_q.push_back('{m_edge + m_dly, int'(data)});
    pre_empty = (m_q.size() == 0);
    m_rv = 0; m_rd = 0;
    if (m_q.size() > 0 && m_q[0].due == m_edge) begin
      m_rv = 1; m_rd = m_q[0].d; void'(m_q.pop_front());
    end
    case (m_mode)
      M_IDLE: begin
        m_cyc = 0;
        if (en) begin
          req = int'(dly);
          m_dly = (req == 0) ? 1 : ((req > MAX_DELAY) ? MAX_DELAY : req);
          m_mode = (DISABLE_CYC == 0) ? M_ARMED : M_WARM;
        end
      end
      M_WARM: begin
        if (!en) begin m_mode = M_IDLE; m_cyc = 0; end
        else begin
          if (m_cyc == DISABLE_CYC - 1) m_mode = M_ARMED;
          m_cyc++;
        end
      end
      M_ARMED: begin
        if (m_cyc < 65535) m_cyc++;
        if (!en) m_mode = M_DRAIN;
      end
      default: begin
        if (pre_empty) begin m_mode = M_IDLE; m_cyc = 0; end
        else if (m_cyc < 65535) m_cyc++;
      end
    endcase
  endtask

  task automatic check_model();
    chk("resp_valid", resp_valid, m_rv);
    chk("resp_data", resp_data, m_rd);
    chk("busy", busy, (m_mode != M_IDLE || m_q.size() > 0) ? 1 : 0);
    chk("cyc", cyc, m_cyc);
    chk("hit_cnt", hit, HIT_EN ? m_hit : 0);
  endtask

  task automatic cycle(input bit e, input int dl, input bit v, input int d);
    en = e; dly = DLY_W'(dl); valid = v; data = WIDTH'(d);
    @(posedge clk);
    model_edge();
    #2;
    check_model();
  endtask

  task automatic do_reset();
    en = 1'b0; valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_hit", hit, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic lat_test(input int dl, input int exp_lat);
    int lat;
    lat = -1;
    cycle(1, dl, 0, 0);
    cycle(1, dl, 0, 0);
    cycle(1, dl, 0, 0);
    cycle(1, (dl == 0) ? 7 : 0, 1, 8'h5C);
    for (int k = 1; k <= 8; k++) begin
      cycle(1, (dl == 0) ? 7 : 0, 0, 0);
      if (resp_valid === 1'b1 && lat < 0) lat = k;
    end
    chk($sformatf("latency_d%0d", dl), lat, exp_lat);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    int last_echo, first_idle, hit_exp;
    int echoes[$];
    bit e_r;

    en = 0; dly = '0; valid = 0; data = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("por_resp_valid", resp_valid, 0);
    chk("por_busy", busy, 0);
    chk("por_cyc", cyc, 0);
    chk("por_hit", hit, 0);
    rst_n = 1'b1;

    // Directed table: delay 3, single beat A5, delay change while armed, drop en.
    tbl[0] = '{1, 3, 0, 0,     0, 0,     1, 0};
    tbl[1] = '{1, 3, 0, 0,     0, 0,     1, 1};
    tbl[2] = '{1, 3, 0, 0,     0, 0,     1, 2};
    tbl[3] = '{1, 3, 1, 8'hA5, 0, 0,     1, 3};
    tbl[4] = '{1, 3, 0, 0,     0, 0,     1, 4};
    tbl[5] = '{1, 3, 0, 0,     0, 0,     1, 5};
    tbl[6] = '{1, 3, 0, 0,     1, 8'hA5, 1, 6};
    tbl[7] = '{1, 0, 0, 0,     0, 0,     1, 7};
    tbl[8] = '{0, 0, 0, 0,     0, 0,     1, 8};
    tbl[9] = '{0, 0, 0, 0,     0, 0,     0, 0};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].en[0], tbl[i].dly, tbl[i].v[0], tbl[i].d);
      chk($sformatf("tbl%0d_rv", i), resp_valid, tbl[i].rv);
      chk($sformatf("tbl%0d_rd", i), resp_data, tbl[i].rd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_cyc", i), cyc, tbl[i].cyc);
    end

    // Delay-1 stream, data = cycle index; first beat accepted at edge 3.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1, 1, 1, i);
      if (i >= 4) begin
        chk("stream_valid", resp_valid, 1);
        chk("stream_data", resp_data, i - 1);
      end else chk("stream_quiet", resp_valid, 0);
    end
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    hit_exp = HIT_EN ? 14 : 0;
    chk("hit_total", hit, hit_exp);

    // Delay clamping; the second value written while armed must be ignored.
    lat_test(0, 1);
    lat_test(7, 4);

    // Drain ordering and busy fall.
    cycle(1, 4, 0, 0);
    cycle(1, 4, 0, 0);
    cycle(1, 4, 0, 0);
    cycle(1, 4, 1, 8'h11);
    cycle(1, 4, 1, 8'h22);
    cycle(0, 4, 1, 8'h33);
    cycle(0, 4, 1, 8'h44);
    last_echo = -1; first_idle = -1;
    for (int j = 0; j < 12; j++) begin
      cycle(0, 4, 0, 0);
      if (resp_valid === 1'b1) begin echoes.push_back(int'(resp_data)); last_echo = j; end
      if (busy === 1'b0 && first_idle < 0) first_idle = j;
    end
    chk("drain_count", echoes.size(), 3);
    if (echoes.size() == 3) begin
      chk("drain_0", echoes[0], 8'h11);
      chk("drain_1", echoes[1], 8'h22);
      chk("drain_2", echoes[2], 8'h33);
    end
    chk("busy_fall", first_idle - last_echo, 1);

    // Reset with two beats in flight at delay 4.
    cycle(1, 4, 0, 0);
    cycle(1, 4, 0, 0);
    cycle(1, 4, 0, 0);
    cycle(1, 4, 1, 8'h77);
    cycle(1, 4, 1, 8'h78);
    do_reset();
    last_echo = 0;
    for (int j = 0; j < 8; j++) begin
      cycle(0, 4, 0, 0);
      if (resp_valid !== 1'b0) last_echo++;
    end
    chk("no_echo_after_reset", last_echo, 0);

    // Randomised traffic against the model.
    e_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 6) e_r = ~e_r;
      cycle(e_r, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
